// File: rtl/dendritic_drain_pkg.sv
// dendritic_drain_pkg: fixed-point widths shared with the spike router
// and the drain sweep state encoding.
package dendritic_drain_pkg;

    localparam int INTEGER_WIDTH   = 16;
    localparam int DATA_WIDTH_FRAC = 32;
    localparam int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC;
    localparam int NEURON_WIDTH    = 11;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READ    = 4'd1,
        ST_CAPTURE = 4'd2,
        ST_PRESENT = 4'd3,
        ST_CLEAR   = 4'd4,
        ST_RESULT  = 4'd5,
        ST_ENQ     = 4'd6,
        ST_NEXT    = 4'd7,
        ST_DONE    = 4'd8
    } drain_state_t;

endpackage

// File: rtl/dendritic_drain_if.sv
// dendritic_drain_if: sum/result handshake between the drain sweep
// (master) and the neuron update unit (slave).
interface dendritic_drain_if #(
    parameter int DATA_WIDTH   = 48,
    parameter int NEURON_WIDTH = 11
);

    logic                           SumValid;
    logic                           SumReady;
    logic signed [DATA_WIDTH-1:0]   ExSumOut;
    logic signed [DATA_WIDTH-1:0]   InSumOut;
    logic        [NEURON_WIDTH-1:0] NeuronIndex;
    logic                           ResultValid;
    logic                           Spiked;

    modport master (
        output SumValid, ExSumOut, InSumOut, NeuronIndex,
        input  SumReady, ResultValid, Spiked
    );

    modport slave (
        input  SumValid, ExSumOut, InSumOut, NeuronIndex,
        output SumReady, ResultValid, Spiked
    );

endinterface

// File: rtl/dendritic_drain.sv
// dendritic_drain: sweeps dendritic RAM, hands Ex/In sums to the neuron
// unit, zeroes each entry and pushes spiking neuron IDs to the spike queue.
module dendritic_drain #(
    parameter int INTEGER_WIDTH   = dendritic_drain_pkg::INTEGER_WIDTH,
    parameter int DATA_WIDTH_FRAC = dendritic_drain_pkg::DATA_WIDTH_FRAC,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NEURON_WIDTH    = dendritic_drain_pkg::NEURON_WIDTH
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           UpdateEnable,
    input  logic                           Initialize,
    input  logic        [NEURON_WIDTH-1:0] NeuStart,
    input  logic        [NEURON_WIDTH-1:0] NeuEnd,
    output logic                           EXChipEnable,
    output logic                           INChipEnable,
    output logic                           EXWriteEnable,
    output logic                           INWriteEnable,
    output logic        [NEURON_WIDTH-1:0] EXAddress,
    output logic        [NEURON_WIDTH-1:0] INAddress,
    input  logic signed [DATA_WIDTH-1:0]   ExWeightSum,
    input  logic signed [DATA_WIDTH-1:0]   InWeightSum,
    output logic signed [DATA_WIDTH-1:0]   NewExWeightSum,
    output logic signed [DATA_WIDTH-1:0]   NewInWeightSum,
    output logic                           QueueWriteEnable,
    output logic        [NEURON_WIDTH-1:0] QueueData,
    input  logic                           QueueFull,
    output logic                           UpdateComplete,
    dendritic_drain_if.master              nif
);

    import dendritic_drain_pkg::*;

    drain_state_t            state;
    logic [NEURON_WIDTH-1:0] idx;
    logic [NEURON_WIDTH-1:0] span;
    logic                    res_pend;
    logic                    res_spk;
    logic                    res_hit;
    logic                    res_spike;

    assign span = NeuEnd - NeuStart;

    // A result seen during CLEAR is parked so RESULT can consume it later.
    assign res_hit   = res_pend | nif.ResultValid;
    assign res_spike = res_pend ? res_spk : nif.Spiked;

    assign NewExWeightSum = '0;
    assign NewInWeightSum = '0;

    always_ff @(posedge Clock) begin
        if (Reset || (Initialize && !UpdateEnable)) begin
            state            <= ST_IDLE;
            idx              <= '0;
            res_pend         <= 1'b0;
            res_spk          <= 1'b0;
            EXChipEnable     <= 1'b0;
            INChipEnable     <= 1'b0;
            EXWriteEnable    <= 1'b0;
            INWriteEnable    <= 1'b0;
            EXAddress        <= '0;
            INAddress        <= '0;
            nif.SumValid     <= 1'b0;
            nif.ExSumOut     <= '0;
            nif.InSumOut     <= '0;
            nif.NeuronIndex  <= '0;
            QueueWriteEnable <= 1'b0;
            QueueData        <= '0;
            UpdateComplete   <= 1'b0;
        end else if (!UpdateEnable) begin
            state            <= ST_IDLE;
            idx              <= '0;
            res_pend         <= 1'b0;
            res_spk          <= 1'b0;
            EXChipEnable     <= 1'b0;
            INChipEnable     <= 1'b0;
            EXWriteEnable    <= 1'b0;
            INWriteEnable    <= 1'b0;
            EXAddress        <= '0;
            INAddress        <= '0;
            nif.SumValid     <= 1'b0;
            QueueWriteEnable <= 1'b0;
            UpdateComplete   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    EXChipEnable <= 1'b1;
                    INChipEnable <= 1'b1;
                    EXAddress    <= idx;
                    INAddress    <= idx;
                    state        <= ST_READ;
                end
                ST_READ: begin
                    EXChipEnable <= 1'b0;
                    INChipEnable <= 1'b0;
                    state        <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    nif.ExSumOut    <= ExWeightSum;
                    nif.InSumOut    <= InWeightSum;
                    nif.NeuronIndex <= idx;
                    nif.SumValid    <= 1'b1;
                    state           <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (nif.SumReady) begin
                        nif.SumValid  <= 1'b0;
                        EXChipEnable  <= 1'b1;
                        INChipEnable  <= 1'b1;
                        EXWriteEnable <= 1'b1;
                        INWriteEnable <= 1'b1;
                        state         <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    EXChipEnable  <= 1'b0;
                    INChipEnable  <= 1'b0;
                    EXWriteEnable <= 1'b0;
                    INWriteEnable <= 1'b0;
                    if (nif.ResultValid) begin
                        res_pend <= 1'b1;
                        res_spk  <= nif.Spiked;
                    end
                    state <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_hit) begin
                        res_pend <= 1'b0;
                        state    <= res_spike ? ST_ENQ : ST_NEXT;
                    end
                end
                ST_ENQ: begin
                    if (!QueueFull) begin
                        QueueWriteEnable <= 1'b1;
                        QueueData        <= idx + NeuStart;
                        state            <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    QueueWriteEnable <= 1'b0;
                    if (idx < span) begin
                        idx          <= idx + 1'b1;
                        EXChipEnable <= 1'b1;
                        INChipEnable <= 1'b1;
                        EXAddress    <= idx + 1'b1;
                        INAddress    <= idx + 1'b1;
                        state        <= ST_READ;
                    end else begin
                        idx            <= '0;
                        UpdateComplete <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    UpdateComplete <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dendritic_drain.sv
// tb_dendritic_drain: directed sweeps against a RAM model and a neuron
// unit responder, with sums and queue IDs checked from scoreboards.
module tb_dendritic_drain;

    import dendritic_drain_pkg::*;

    localparam int DW    = DATA_WIDTH;
    localparam int NW    = NEURON_WIDTH;
    localparam int DEPTH = 1 << NW;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 UpdateEnable;
    logic                 Initialize;
    logic [NW-1:0]        NeuStart;
    logic [NW-1:0]        NeuEnd;
    logic                 EXChipEnable;
    logic                 INChipEnable;
    logic                 EXWriteEnable;
    logic                 INWriteEnable;
    logic [NW-1:0]        EXAddress;
    logic [NW-1:0]        INAddress;
    logic signed [DW-1:0] ExWeightSum;
    logic signed [DW-1:0] InWeightSum;
    logic signed [DW-1:0] NewExWeightSum;
    logic signed [DW-1:0] NewInWeightSum;
    logic                 QueueWriteEnable;
    logic [NW-1:0]        QueueData;
    logic                 QueueFull;
    logic                 UpdateComplete;

    dendritic_drain_if #(.DATA_WIDTH(DW), .NEURON_WIDTH(NW)) nif ();

    dendritic_drain dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .UpdateEnable     (UpdateEnable),
        .Initialize       (Initialize),
        .NeuStart         (NeuStart),
        .NeuEnd           (NeuEnd),
        .EXChipEnable     (EXChipEnable),
        .INChipEnable     (INChipEnable),
        .EXWriteEnable    (EXWriteEnable),
        .INWriteEnable    (INWriteEnable),
        .EXAddress        (EXAddress),
        .INAddress        (INAddress),
        .ExWeightSum      (ExWeightSum),
        .InWeightSum      (InWeightSum),
        .NewExWeightSum   (NewExWeightSum),
        .NewInWeightSum   (NewInWeightSum),
        .QueueWriteEnable (QueueWriteEnable),
        .QueueData        (QueueData),
        .QueueFull        (QueueFull),
        .UpdateComplete   (UpdateComplete),
        .nif              (nif)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [NW-1:0] idx;
        logic [DW-1:0] ex_s;
        logic [DW-1:0] in_s;
    } sum_t;

    sum_t          sum_q[$];
    logic [NW-1:0] push_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] ex_val(input int mode, input int i);
        if (mode == 0) return DW'(100);
        return DW'(1000 * (i + 1) + mode);
    endfunction

    function automatic logic [DW-1:0] in_val(input int mode, input int i);
        if (mode == 0) return -DW'(40);
        return -DW'(3 * i + 7 + mode);
    endfunction

    // RAM model: 1-cycle read latency, garbage outside the capture cycle
    logic [DW-1:0] ex_mem [DEPTH];
    logic [DW-1:0] in_mem [DEPTH];
    int fill_seq = 0;
    int fill_seen = 0;
    int fill_mode = 0;
    int cyc = 0;
    int ex_wr = 0;
    int in_wr = 0;
    int wr_bad = 0;
    int hs_cnt = 0;
    logic [NW-1:0] last_hs_idx = '0;

    always @(posedge Clock) begin
        cyc++;
        if (fill_seq != fill_seen) begin
            for (int i = 0; i < DEPTH; i++) begin
                ex_mem[i] = ex_val(fill_mode, i);
                in_mem[i] = in_val(fill_mode, i);
            end
            fill_seen = fill_seq;
        end
        ExWeightSum <= 48'hDEAD_BEEF_0BAD;
        InWeightSum <= 48'hBAD0_FEED_DEAD;
        if (EXChipEnable) begin
            if (EXWriteEnable) begin
                ex_mem[EXAddress] = NewExWeightSum;
                ex_wr++;
                if (NewExWeightSum != 0 || EXAddress != last_hs_idx ||
                    ex_wr > hs_cnt) wr_bad++;
            end else begin
                ExWeightSum <= ex_mem[EXAddress];
            end
        end
        if (INChipEnable) begin
            if (INWriteEnable) begin
                in_mem[INAddress] = NewInWeightSum;
                in_wr++;
                if (NewInWeightSum != 0 || INAddress != last_hs_idx ||
                    in_wr > hs_cnt) wr_bad++;
            end else begin
                InWeightSum <= in_mem[INAddress];
            end
        end
    end

    // Neuron unit responder plus output monitors
    int ready_delay = 0;
    int result_delay = 0;
    int exp_gap = 0;
    int gap_from = 0;
    logic [31:0] spike_mask = '0;
    int push_cnt = 0;
    int done_cnt = 0;
    int wait_cnt = 0;
    int res_cnt = 0;
    logic res_spk_q = 1'b0;
    int last_hs_cyc = 0;
    logic [DW-1:0] hold_ex;
    logic [DW-1:0] hold_in;
    logic [NW-1:0] hold_idx;
    sum_t e;

    always @(negedge Clock) begin
        nif.SumReady    = 1'b0;
        nif.ResultValid = 1'b0;
        nif.Spiked      = 1'b0;
        if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
                nif.ResultValid = 1'b1;
                nif.Spiked      = res_spk_q;
            end
        end
        if (!nif.SumValid || Reset) begin
            wait_cnt = 0;
        end else if (wait_cnt < ready_delay) begin
            if (wait_cnt == 0) begin
                hold_ex  = $unsigned(nif.ExSumOut);
                hold_in  = $unsigned(nif.InSumOut);
                hold_idx = nif.NeuronIndex;
            end else begin
                check("stall_ex_stable", $unsigned(nif.ExSumOut), hold_ex);
                check("stall_in_stable", $unsigned(nif.InSumOut), hold_in);
                check("stall_idx_stable", nif.NeuronIndex, hold_idx);
            end
            wait_cnt++;
        end else begin
            nif.SumReady = 1'b1;
            wait_cnt = 0;
            hs_cnt++;
            if (sum_q.size() == 0) begin
                check("sum_unexpected", 1, 0);
            end else begin
                e = sum_q.pop_front();
                check("hs_index", nif.NeuronIndex, e.idx);
                check("hs_ex_sum", $unsigned(nif.ExSumOut), e.ex_s);
                check("hs_in_sum", $unsigned(nif.InSumOut), e.in_s);
            end
            if (exp_gap != 0 && hs_cnt > gap_from)
                check("hs_gap_cycles", cyc - last_hs_cyc, exp_gap);
            last_hs_cyc = cyc;
            last_hs_idx = nif.NeuronIndex;
            res_cnt     = 1 + result_delay;
            res_spk_q   = spike_mask[nif.NeuronIndex[4:0]];
        end
        if (QueueWriteEnable) begin
            push_cnt++;
            check("push_while_full", QueueFull, 0);
            if (push_q.size() == 0) check("push_unexpected", 1, 0);
            else check("push_id", QueueData, push_q.pop_front());
        end
        if (UpdateComplete) begin
            done_cnt++;
            if (exp_gap != 0)
                check("done_latency", cyc - last_hs_cyc, 4);
        end
    end

    int b_hs, b_ex, b_in, b_push, b_done, b_bad, cur_span;

    task automatic snap();
        b_hs     = hs_cnt;
        b_ex     = ex_wr;
        b_in     = in_wr;
        b_push   = push_cnt;
        b_done   = done_cnt;
        b_bad    = wr_bad;
        gap_from = hs_cnt + 1;
    endtask

    task automatic start_sweep(input int s, input int en, input int mode,
                               input logic [31:0] mask);
        cur_span   = (en - s) & (DEPTH - 1);
        NeuStart   = NW'(s);
        NeuEnd     = NW'(en);
        spike_mask = mask;
        fill_mode  = mode;
        fill_seq++;
        @(negedge Clock);
        @(negedge Clock);
        for (int i = 0; i <= cur_span; i++) begin
            sum_q.push_back(sum_t'{idx: NW'(i), ex_s: ex_val(mode, i),
                                   in_s: in_val(mode, i)});
            if (mask[i]) push_q.push_back(NW'(i + s));
        end
        UpdateEnable = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == b_done && k < budget) begin
            @(negedge Clock);
            k++;
        end
        check("sweep_completes", done_cnt != b_done, 1);
    endtask

    task automatic wait_hs(input int budget);
        int k = 0;
        while (hs_cnt == b_hs && k < budget) begin
            @(negedge Clock);
            k++;
        end
        check("first_handshake_seen", hs_cnt != b_hs, 1);
    endtask

    task automatic end_checks(input int n, input int pushes);
        int nz = 0;
        check("n_handshakes", hs_cnt - b_hs, n);
        check("ex_zero_writes", ex_wr - b_ex, n);
        check("in_zero_writes", in_wr - b_in, n);
        check("queue_pushes", push_cnt - b_push, pushes);
        check("done_pulses", done_cnt - b_done, 1);
        check("write_order", wr_bad - b_bad, 0);
        check("sum_q_drained", sum_q.size(), 0);
        check("push_q_drained", push_q.size(), 0);
        for (int i = 0; i <= cur_span; i++)
            if (ex_mem[i] != 0 || in_mem[i] != 0) nz++;
        check("ram_cleared", nz, 0);
    endtask

    task automatic run_sweep(input int s, input int en, input int mode,
                             input logic [31:0] mask, input int n,
                             input int pushes);
        snap();
        start_sweep(s, en, mode, mask);
        wait_done(400);
        repeat (3) @(negedge Clock);
        end_checks(n, pushes);
        UpdateEnable = 1'b0;
        @(negedge Clock);
    endtask

    task automatic check_quiet(input string pfx, input bit full);
        check({pfx, "_strobes"},
              {EXChipEnable, INChipEnable, EXWriteEnable, INWriteEnable,
               nif.SumValid, QueueWriteEnable, UpdateComplete}, 0);
        check({pfx, "_addr"}, {EXAddress, INAddress}, 0);
        if (full) begin
            check({pfx, "_ex_sum"}, $unsigned(nif.ExSumOut), 0);
            check({pfx, "_in_sum"}, $unsigned(nif.InSumOut), 0);
            check({pfx, "_idx_qdata"}, {nif.NeuronIndex, QueueData}, 0);
            check({pfx, "_new_sums"}, $unsigned(NewExWeightSum) |
                  $unsigned(NewInWeightSum), 0);
        end
    endtask

    initial begin
        Reset        = 1'b1;
        UpdateEnable = 1'b0;
        Initialize   = 1'b0;
        QueueFull    = 1'b0;
        NeuStart     = '0;
        NeuEnd       = '0;
        repeat (3) @(negedge Clock);
        check_quiet("reset", 1'b1);
        Reset = 1'b0;
        @(negedge Clock);

        // Uniform sums, immediate handshakes, no spikes
        exp_gap = 6;
        run_sweep(0, 3, 0, 32'h0, 4, 0);
        exp_gap = 0;

        // Spikes at indices 1 and 4, results one cycle later
        result_delay = 1;
        run_sweep(5, 9, 1, 32'h12, 5, 2);
        result_delay = 0;

        // Queue full while a spike waits to be enqueued
        QueueFull = 1'b1;
        snap();
        start_sweep(20, 22, 2, 32'h1);
        wait_hs(100);
        repeat (12) @(negedge Clock);
        check("no_push_while_full", push_cnt - b_push, 0);
        QueueFull = 1'b0;
        @(negedge Clock);
        check("push_after_full_drops", QueueWriteEnable, 1);
        wait_done(400);
        repeat (3) @(negedge Clock);
        end_checks(3, 1);
        UpdateEnable = 1'b0;
        @(negedge Clock);

        // Slow acceptance holds SumValid and stable data
        ready_delay = 3;
        run_sweep(0, 2, 3, 32'h0, 3, 0);

        // Abort while presenting index 2
        ready_delay = 2;
        snap();
        start_sweep(0, 4, 3, 32'h0);
        for (int k = 0; k < 200; k++) begin
            if (nif.SumValid && nif.NeuronIndex == 2) break;
            @(negedge Clock);
        end
        check("abort_at_idx2", {nif.SumValid, nif.NeuronIndex}, {1'b1, NW'(2)});
        UpdateEnable = 1'b0;
        @(negedge Clock);
        check_quiet("abort", 1'b0);
        check("abort_handshakes", hs_cnt - b_hs, 2);
        check("abort_writes", ex_wr - b_ex, 2);
        repeat (4) @(negedge Clock);
        check("abort_no_done", done_cnt - b_done, 0);
        sum_q.delete();
        Initialize = 1'b1;
        @(negedge Clock);
        Initialize = 1'b0;
        check_quiet("initialize", 1'b1);
        ready_delay = 0;
        run_sweep(0, 1, 4, 32'h0, 2, 0);

        // Reset while stuck in enqueue
        QueueFull = 1'b1;
        snap();
        start_sweep(7, 9, 5, 32'h1);
        wait_hs(100);
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check_quiet("reset_mid_enq", 1'b1);
        Reset        = 1'b0;
        UpdateEnable = 1'b0;
        QueueFull    = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_no_push", push_cnt - b_push, 0);
        sum_q.delete();
        push_q.delete();

        // Single-neuron sweep and a wrapping ID range
        run_sweep(12, 12, 6, 32'h1, 1, 1);
        run_sweep(2046, 1, 7, 32'hC, 4, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
